// File: rtl/types_pkg.sv
// Shared types and opcode constants
// for the R-type execution unit.
package types_pkg;

  typedef enum logic [1:0] {
    ALU_IDLE,
    ALU_BUSY,
    ALU_DONE
  } ALU_STATE;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_SUB  = 3'b000;
  localparam logic [2:0] F3_SRA  = 3'b101;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring
// divide, one bit per clock on magnitudes.
module alu_muldiv_iter
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] b_q;
  logic            div_q;
  logic [XLEN-1:0] cur_hi;
  logic [XLEN-1:0] cur_lo;
  logic [XLEN-1:0] cur_b;
  logic            cur_div;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   t;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [XLEN-1:0] nxt_hi;
  logic [XLEN-1:0] nxt_lo;

  assign done = (count == CW'(XLEN));
  assign busy = (count != '0) && !done;

  // One step; at start it runs on the fresh
  // operands so XLEN steps end XLEN-1 edges on.
  always_comb begin
    cur_hi  = start ? '0 : hi;
    cur_lo  = start ? a : lo;
    cur_b   = start ? b : b_q;
    cur_div = start ? is_div : div_q;
    sum = {1'b0, cur_hi}
        + (cur_lo[0] ? {1'b0, cur_b} : '0);
    t    = {cur_hi, cur_lo[XLEN-1]};
    ge   = (t >= {1'b0, cur_b});
    diff = t[XLEN-1:0] - cur_b;
    if (cur_div) begin
      nxt_hi = ge ? diff : t[XLEN-1:0];
      nxt_lo = {cur_lo[XLEN-2:0], ge};
    end else begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], cur_lo[XLEN-1:1]};
    end
  end

  // Counter and working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      count <= CW'(1);
      hi    <= nxt_hi;
      lo    <= nxt_lo;
      b_q   <= b;
      div_q <= is_div;
    end else if (busy) begin
      count <= count + CW'(1);
      hi    <= nxt_hi;
      lo    <= nxt_lo;
    end
  end

endmodule

// File: rtl/rtype_alu_seq.sv
// Handshaked R-type execution unit: base ALU
// ops in one cycle, M ops via iterative engine.
module rtype_alu_seq
  import types_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_funct7,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_error
);

  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  ALU_STATE state, state_nxt;

  logic            accept;
  logic            is_base;
  logic            is_alt;
  logic            is_md;
  logic            illegal;
  logic [XLEN-1:0] base_res;
  logic [SW-1:0]   shamt;
  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] ma;
  logic [XLEN-1:0] mb;
  logic            neg_in;
  logic            spec_in;
  logic [XLEN-1:0] spec_res_in;

  logic [2:0]      f3_q;
  logic            neg_q;
  logic            spec_q;
  logic [XLEN-1:0] spec_res_q;

  logic            md_busy;
  logic            md_done;
  logic            md_fin;
  logic [XLEN-1:0] md_hi;
  logic [XLEN-1:0] md_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] div_val;
  logic [XLEN-1:0] div_fix;
  logic [XLEN-1:0] m_res;

  assign accept = in_valid && in_ready;
  assign md_fin = md_done && !md_busy;
  assign shamt  = in_rs2[SW-1:0];

  // Decode legality and the base-op result.
  always_comb begin
    is_base  = (in_funct7 == FUNCT7_BASE);
    is_alt   = (in_funct7 == FUNCT7_ALT)
            && (in_funct3 == F3_SUB
             || in_funct3 == F3_SRA);
    is_md    = ENABLE_M
            && (in_funct7 == FUNCT7_MULDIV);
    illegal  = !(is_base || is_alt || is_md);
    base_res = '0;
    if (is_alt) begin
      if (in_funct3 == F3_SUB)
        base_res = in_rs1 - in_rs2;
      else
        base_res = $signed(in_rs1) >>> shamt;
    end else if (is_base) begin
      unique case (in_funct3)
        F3_ADD:  base_res = in_rs1 + in_rs2;
        F3_SLL:  base_res = in_rs1 << shamt;
        F3_SLT:  base_res = XLEN'(
          $signed(in_rs1) < $signed(in_rs2));
        F3_SLTU: base_res = XLEN'(in_rs1 < in_rs2);
        F3_XOR:  base_res = in_rs1 ^ in_rs2;
        F3_SRL:  base_res = in_rs1 >> shamt;
        F3_OR:   base_res = in_rs1 | in_rs2;
        F3_AND:  base_res = in_rs1 & in_rs2;
        default: base_res = '0;
      endcase
    end
  end

  // Magnitudes, result sign and special cases.
  always_comb begin
    a_sgn = (in_funct3 == F3_MULH)
         || (in_funct3 == F3_MULHSU)
         || (in_funct3 == F3_DIV)
         || (in_funct3 == F3_REM);
    b_sgn = (in_funct3 == F3_MULH)
         || (in_funct3 == F3_DIV)
         || (in_funct3 == F3_REM);
    a_neg = a_sgn && in_rs1[XLEN-1];
    b_neg = b_sgn && in_rs2[XLEN-1];
    ma = a_neg ? -in_rs1 : in_rs1;
    mb = b_neg ? -in_rs2 : in_rs2;
    if (in_funct3[2] && in_funct3[1])
      neg_in = a_neg;
    else
      neg_in = a_neg ^ b_neg;
    spec_in     = 1'b0;
    spec_res_in = '0;
    if (in_funct3[2] && in_rs2 == '0) begin
      spec_in     = 1'b1;
      spec_res_in = in_funct3[1] ? in_rs1 : '1;
    end else if (in_funct3[2] && a_sgn
              && in_rs1 == MIN_NEG
              && in_rs2 == '1) begin
      spec_in     = 1'b1;
      spec_res_in = in_funct3[1] ? '0 : in_rs1;
    end
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_md),
    .is_div (in_funct3[2]),
    .a      (ma),
    .b      (mb),
    .busy   (md_busy),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  // Sign-correct the engine output.
  always_comb begin
    prod     = {md_hi, md_lo};
    prod_fix = neg_q ? -prod : prod;
    div_val  = f3_q[1] ? md_hi : md_lo;
    div_fix  = neg_q ? -div_val : div_val;
    if (f3_q[2])
      m_res = div_fix;
    else if (f3_q == F3_MUL)
      m_res = prod_fix[XLEN-1:0];
    else
      m_res = prod_fix[2*XLEN-1:XLEN];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ALU_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ALU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = is_md ? ALU_BUSY
                            : ALU_DONE;
      end
      ALU_BUSY: begin
        if (md_fin) state_nxt = ALU_DONE;
      end
      ALU_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ALU_IDLE;
      end
      default: state_nxt = ALU_IDLE;
    endcase
  end

  // Latch op context and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else if (accept) begin
      f3_q       <= in_funct3;
      neg_q      <= neg_in;
      spec_q     <= spec_in;
      spec_res_q <= spec_res_in;
      out_error  <= illegal;
      if (!is_md) out_result <= base_res;
    end else if (state == ALU_BUSY && md_fin) begin
      out_result <= spec_q ? spec_res_q : m_res;
    end
  end

endmodule

// File: tb/tb_rtype_alu_seq.sv
// Directed self-checking bench for
// rtype_alu_seq with XLEN=32, ENABLE_M=1.
module tb_rtype_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t bv[10];
  vec_t mv[14];

  always #5 clk = ~clk;

  rtype_alu_seq #(
    .XLEN(32),
    .ENABLE_M(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct7  (in_funct7),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error)
  );

  // Accept one op, return result and cycles
  // from accept edge until out_valid is seen.
  task automatic run_op(
    input  logic [6:0]  f7,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        err,
    output int          lat
  );
    in_funct7 = f7;
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_rs1    = $urandom;
    in_rs2    = $urandom;
    in_funct3 = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_result;
    err = out_error;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_funct7 = '0;
    in_funct3 = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0
        || out_result !== 32'h0
        || out_error !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b res=%h err=%b want 1 0 0 0",
               in_ready, out_valid, out_result,
               out_error);
    end
  endtask

  task automatic test_base;
    logic [31:0] r;
    logic e;
    int l;
    bv[0] = '{7'h00, 3'd0, 32'd5, 32'd7, 32'd12, "add"};
    bv[1] = '{7'h20, 3'd0, 32'd0, 32'd1, 32'hFFFFFFFF, "sub"};
    bv[2] = '{7'h20, 3'd5, 32'h80000000, 32'd4, 32'hF8000000, "sra"};
    bv[3] = '{7'h00, 3'd2, 32'hFFFFFFFB, 32'd3, 32'd1, "slt"};
    bv[4] = '{7'h00, 3'd3, 32'hFFFFFFFB, 32'd3, 32'd0, "sltu"};
    bv[5] = '{7'h00, 3'd1, 32'd1, 32'd33, 32'd2, "sll33"};
    bv[6] = '{7'h00, 3'd5, 32'h80000000, 32'd4, 32'h08000000, "srl"};
    bv[7] = '{7'h00, 3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor"};
    bv[8] = '{7'h00, 3'd6, 32'hF0F0F0F0, 32'h0000FF00, 32'hF0F0FFF0, "or"};
    bv[9] = '{7'h00, 3'd7, 32'hF0F0F0F0, 32'h0000FF00, 32'h0000F000, "and"};
    for (int i = 0; i < 10; i++) begin
      run_op(bv[i].f7, bv[i].f3, bv[i].a,
             bv[i].b, r, e, l);
      total++;
      if (r !== bv[i].exp || e !== 1'b0) begin
        bad++;
        $display("FAIL %s: res=%h err=%b want %h 0",
                 bv[i].name, r, e, bv[i].exp);
      end
      total++;
      if (l != 1) begin
        bad++;
        $display("FAIL %s latency: got %0d want 1",
                 bv[i].name, l);
      end
    end
  endtask

  task automatic test_muldiv;
    logic [31:0] r;
    logic e;
    int l;
    mv[0]  = '{7'h01, 3'd0, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFF4, "mul"};
    mv[1]  = '{7'h01, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, "mulh"};
    mv[2]  = '{7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu"};
    mv[3]  = '{7'h01, 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu"};
    mv[4]  = '{7'h01, 3'd1, 32'h40000000, 32'd4, 32'd1, "mulh_pos"};
    mv[5]  = '{7'h01, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div"};
    mv[6]  = '{7'h01, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem"};
    mv[7]  = '{7'h01, 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF, "divu0"};
    mv[8]  = '{7'h01, 3'd7, 32'd9, 32'd0, 32'd9, "remu0"};
    mv[9]  = '{7'h01, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
    mv[10] = '{7'h01, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf"};
    mv[11] = '{7'h01, 3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, "div_negd"};
    mv[12] = '{7'h01, 3'd6, 32'd100, 32'hFFFFFFF9, 32'd2, "rem_negd"};
    mv[13] = '{7'h01, 3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem0"};
    for (int i = 0; i < 14; i++) begin
      run_op(mv[i].f7, mv[i].f3, mv[i].a,
             mv[i].b, r, e, l);
      total++;
      if (r !== mv[i].exp || e !== 1'b0) begin
        bad++;
        $display("FAIL %s: res=%h err=%b want %h 0",
                 mv[i].name, r, e, mv[i].exp);
      end
      total++;
      if (l != 33) begin
        bad++;
        $display("FAIL %s latency: got %0d want 33",
                 mv[i].name, l);
      end
    end
  endtask

  task automatic test_stall;
    int l;
    in_funct7 = 7'h00;
    in_funct3 = 3'd0;
    in_rs1    = 32'd10;
    in_rs2    = 32'd20;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_funct7 = 7'h00;
    in_funct3 = 3'd4;
    in_rs1    = 32'hFF;
    in_rs2    = 32'h0F;
    l = 0;
    while (!out_valid && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1
          || out_result !== 32'd30
          || out_error !== 1'b0
          || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: vld=%b res=%h rdy=%b want 1 1e 0",
                 i, out_valid, out_result, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] r;
    logic e;
    int l;
    run_op(7'h7F, 3'd0, 32'h1234, 32'h5678,
           r, e, l);
    total++;
    if (r !== 32'h0 || e !== 1'b1 || l != 1) begin
      bad++;
      $display("FAIL illegal_7f: res=%h err=%b lat=%0d want 0 1 1",
               r, e, l);
    end
    run_op(7'h20, 3'd1, 32'h1234, 32'h5678,
           r, e, l);
    total++;
    if (r !== 32'h0 || e !== 1'b1) begin
      bad++;
      $display("FAIL illegal_alt: res=%h err=%b want 0 1",
               r, e);
    end
    run_op(7'h00, 3'd0, 32'd1, 32'd1, r, e, l);
    total++;
    if (r !== 32'd2 || e !== 1'b0) begin
      bad++;
      $display("FAIL after_illegal: res=%h err=%b want 2 0",
               r, e);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r;
    logic e;
    int l;
    int seen;
    in_funct7 = 7'h01;
    in_funct3 = 3'd4;
    in_rs1    = 32'd1000;
    in_rs2    = 32'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_ready: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_novalid: valid cycles=%0d want 0",
               seen);
    end
    run_op(7'h01, 3'd5, 32'd1000, 32'd7,
           r, e, l);
    total++;
    if (r !== 32'd142 || e !== 1'b0 || l != 33) begin
      bad++;
      $display("FAIL abort_recover: res=%h err=%b lat=%0d want 8e 0 33",
               r, e, l);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_muldiv();
    test_stall();
    test_illegal();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/rtype_alu_seq.md
# rtype_alu_seq

Parametrised, handshaked execution unit for RISC-V R-type operations: RV32I/RV64I register-register ALU ops, plus the M extension (MUL/MULH*/DIV*/REM*) computed iteratively. It sits in the processor's RUN_COMMAND step. The control FSM presents decoded funct7/funct3 and two register operands, then waits for the result. The result is written back in SAVE_IN_REGISTER.

## Interface
- `XLEN`, 32: operand/result width; 32 or 64.
- `ENABLE_M`, 1: 1 = funct7 0000001 executes M ops; 0 = flags them illegal.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept; equals (state == ALU_IDLE).
- `in_funct7` input 7: R-type funct7.
- `in_funct3` input 3: R-type funct3.
- `in_rs1` input XLEN: first operand.
- `in_rs2` input XLEN: second operand.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes result.
- `out_result` output XLEN: result, registered.
- `out_error` output 1: op was illegal; registered, qualified by `out_valid`.

## Operation
- States:
  - ALU_IDLE –accept→ ALU_BUSY (M op) or ALU_DONE (base/illegal op).
  - ALU_BUSY –iteration count reaches XLEN→ ALU_DONE.
  - ALU_DONE –`out_valid && out_ready`→ ALU_IDLE.
- Accept = `in_valid && in_ready`. Operands and funct fields are latched at accept; inputs are don't-care afterwards.
- funct7 0000000, by funct3 000..111: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- funct7 0100000: funct3 000 = SUB, 101 = SRA; any other funct3 is illegal.
- funct7 0000001 (ENABLE_M=1), by funct3 000..111: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Any other funct7 is illegal: `out_error`=1, `out_result`=0.
- Shift amount is `rs2[$clog2(XLEN)-1:0]`. SLT/SLTU produce a zero-extended 0/1.
- All arithmetic wraps modulo 2^XLEN.
- MUL returns low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return high XLEN bits.
  - MULH: signed×signed. MULHSU: signed rs1 × unsigned rs2. MULHU: unsigned×unsigned.
- Multiply: shift-add on operand magnitudes, one bit per cycle, then sign correction of the 2·XLEN product.
- Divide: restoring division on magnitudes, one bit per cycle.
  - Quotient takes the sign of rs1 XOR rs2.
  - Remainder takes the sign of rs1.
- Special cases, detected at accept, same latency as normal M ops:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = most negative value, rs2 = −1): DIV = rs1; REM = 0.
- Result and error are held stable while `out_valid && !out_ready`.
- No new accept until the result is taken. Peak throughput is one base op per 2 cycles.

## Timing
- Reset values:
  - state = ALU_IDLE, so `in_ready`=1.
  - `out_valid`=0, `out_result`=0, `out_error`=0.
  - Iteration counter and working registers = 0.
- Reset in any state aborts the operation. No result is emitted; `in_ready`=1 in the first cycle after reset deasserts.
- Base and illegal ops: accept at edge N, `out_valid`=1 from cycle N+1.
- M ops: accept at edge N, `out_valid`=1 from cycle N+1+XLEN. That is 33 cycles for XLEN=32 and 65 for XLEN=64.
- Iteration counter: $clog2(XLEN)+1 bits; it never wraps within an op.
- `in_ready` falls in the cycle after accept. It rises in the cycle after the result handshake.
- `out_valid` falls in the cycle after `out_valid && out_ready`.
- `in_valid` asserted while `in_ready`=0 is ignored; the requester must hold it.

## Structure
- `types_pkg` additions:
  - `ALU_STATE` enum {ALU_IDLE, ALU_BUSY, ALU_DONE}.
  - localparams FUNCT7_BASE = 7'b0000000, FUNCT7_ALT = 7'b0100000, FUNCT7_MULDIV = 7'b0000001.
  - funct3 localparams for each op.
- One sub-module, `alu_muldiv_iter`: the iterative multiply/divide engine.
  - Interface: start/busy/done, operands, op select.
  - It owns the counter and the partial product/remainder registers.
- The top level holds the FSM, base-op combinational datapath, special-case detection and output registers.

## Test plan
- ADD rs1=5, rs2=7 → `out_result`=12, `out_error`=0, `out_valid` one cycle after accept.
- SUB 0−1 → 0xFFFFFFFF; SRA 0x80000000 by 4 → 0xF8000000; SLT −5,3 → 1; SLTU −5,3 → 0; SLL by 33 → shift by 1.
- MUL 3×−4 → 0xFFFFFFF4; MULH −1×−1 → 0; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; latency 33 cycles.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 9/0 → 0xFFFFFFFF, REMU → 9; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Hold `out_ready`=0 for 5 cycles after `out_valid` → result stable, `in_ready`=0, second request ignored until the handshake completes.
- funct7=0x7F → `out_error`=1, result 0. Assert `reset` at cycle 10 of a DIV → no `out_valid`; `in_ready`=1 the cycle after reset deasserts.
